// File: rtl/cp0_irq_ctrl.sv
// CP0 for the MIPS core: Status/Cause/EPC/Count/Compare, exception
// and interrupt arbitration, Count/Compare timer and fetch redirect.
module cp0_irq_ctrl #(
  parameter int          NUM_IRQ    = 6,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0004,
  parameter logic [31:0] EPC_OFFSET = 32'h0040_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mfc0,
  input  logic               mtc0,
  input  logic [4:0]         addr,
  input  logic [31:0]        wdata,
  input  logic [31:0]        pc,
  input  logic               exception,
  input  logic [4:0]         ex_type,
  input  logic               eret,
  input  logic [NUM_IRQ-1:0] irq,
  output logic [31:0]        rdata,
  output logic               redirect,
  output logic [31:0]        redirect_pc,
  output logic               irq_take
);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  logic               ie_q, ie_d;
  logic               exl_q, exl_d;
  logic [7:0]         im_q, im_d;
  logic [4:0]         exc_q, exc_d;
  logic [5:0]         ip_q, ip_d;
  logic               ti_q, ti_d;
  logic [31:0]        epc_q, epc_d;
  logic [31:0]        count_q, count_d;
  logic [31:0]        cmp_q, cmp_d;
  logic [NUM_IRQ-1:0] s1_q, s2_q;

  logic [5:0]  ext;
  logic [5:0]  ip_eff;
  logic        pend;
  logic        eret_fire;
  logic        exc_fire;
  logic        take;
  logic        wr_en;
  logic [31:0] status_v;
  logic [31:0] cause_v;
  logic [31:0] epc_new;

  // Lines are MSB-aligned: the top line lands on IP7 beside the timer.
  always_comb begin
    ext = '0;
    ext[5 -: NUM_IRQ] = s2_q;
  end

  assign ip_eff    = ip_q | {ti_q, 5'b0};
  assign pend      = |(ip_eff & im_q[7:2]);
  assign eret_fire = eret & exl_q;
  assign exc_fire  = exception & ~eret_fire;
  assign take      = ie_q & ~exl_q & pend
                   & ~exception & ~eret;
  assign wr_en     = mtc0 & ~(eret_fire | exc_fire | take);
  assign epc_new   = pc + EPC_OFFSET;

  always_comb begin
    status_v       = '0;
    status_v[0]    = ie_q;
    status_v[1]    = exl_q;
    status_v[15:8] = im_q;
  end

  always_comb begin
    cause_v        = '0;
    cause_v[6:2]   = exc_q;
    cause_v[15:10] = ip_eff;
    cause_v[30]    = ti_q;
  end

  always_comb begin
    ie_d    = ie_q;
    exl_d   = exl_q;
    im_d    = im_q;
    exc_d   = exc_q;
    ip_d    = ext;
    epc_d   = epc_q;
    count_d = count_q + 32'd1;
    cmp_d   = cmp_q;
    ti_d    = ti_q | (count_q == cmp_q);
    unique case (1'b1)
      eret_fire: exl_d = 1'b0;
      exc_fire: begin
        exc_d = ex_type;
        exl_d = 1'b1;
        if (!exl_q) epc_d = epc_new;
      end
      take: begin
        exc_d = 5'd0;
        exl_d = 1'b1;
        epc_d = epc_new;
      end
      wr_en: begin
        unique case (addr)
          REG_COUNT: count_d = wdata;
          REG_COMPARE: begin
            cmp_d = wdata;
            ti_d  = 1'b0;
          end
          REG_STATUS: begin
            ie_d  = wdata[0];
            exl_d = wdata[1];
            im_d  = wdata[15:8];
          end
          REG_EPC: epc_d = wdata;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie_q    <= 1'b0;
      exl_q   <= 1'b0;
      im_q    <= '0;
      exc_q   <= '0;
      ip_q    <= '0;
      ti_q    <= 1'b0;
      epc_q   <= '0;
      count_q <= '0;
      cmp_q   <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
    end else begin
      ie_q    <= ie_d;
      exl_q   <= exl_d;
      im_q    <= im_d;
      exc_q   <= exc_d;
      ip_q    <= ip_d;
      ti_q    <= ti_d;
      epc_q   <= epc_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      s1_q    <= irq;
      s2_q    <= s1_q;
    end
  end

  always_comb begin
    rdata = '0;
    if (mfc0 && rst_n) begin
      unique case (addr)
        REG_COUNT:   rdata = count_q;
        REG_COMPARE: rdata = cmp_q;
        REG_STATUS:  rdata = status_v;
        REG_CAUSE:   rdata = cause_v;
        REG_EPC:     rdata = epc_q;
        default:     rdata = '0;
      endcase
    end
  end

  always_comb begin
    redirect_pc = '0;
    if (rst_n) begin
      if (eret_fire) redirect_pc = epc_q;
      else if (exc_fire || take) redirect_pc = EXC_VECTOR;
    end
  end

  assign redirect = rst_n & (eret_fire | exc_fire | take);
  assign irq_take = rst_n & take;

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Directed bench for cp0_irq_ctrl: reset, exceptions, ERET,
// synchronised interrupts, timer and collision cases.
module tb_cp0_irq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        mfc0;
  logic        mtc0;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] pc;
  logic        exception;
  logic [4:0]  ex_type;
  logic        eret;
  logic [5:0]  irq;
  logic [31:0] rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        irq_take;

  int nvec;
  int nerr;

  cp0_irq_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mfc0        (mfc0),
    .mtc0        (mtc0),
    .addr        (addr),
    .wdata       (wdata),
    .pc          (pc),
    .exception   (exception),
    .ex_type     (ex_type),
    .eret        (eret),
    .irq         (irq),
    .rdata       (rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .irq_take    (irq_take)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    mfc0 = 1'b1;
    addr = a;
    #1;
    d = rdata;
    mfc0 = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    mtc0  = 1'b1;
    addr  = a;
    wdata = d;
    cyc();
    mtc0  = 1'b0;
  endtask

  logic [31:0] v;
  logic        seen;

  initial begin
    nvec = 0; nerr = 0;
    rst_n = 1'b0; mfc0 = 0; mtc0 = 0; addr = 0; wdata = 0;
    pc = 0; exception = 0; ex_type = 0; eret = 0; irq = 0;
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (5) cyc();

    // async reset mid-cycle, outputs forced low
    #2 rst_n = 1'b0;
    exception = 1'b1;
    #1;
    chk("rst_redirect", {31'b0, redirect}, 32'd0);
    chk("rst_rpc", redirect_pc, 32'd0);
    exception = 1'b0;
    rd(5'd9, v);  chk("rst_count", v, 32'd0);
    rd(5'd12, v); chk("rst_status", v, 32'd0);
    cyc();
    #2 rst_n = 1'b1;
    rd(5'd9, v);  chk("count_rel0", v, 32'd0);
    cyc();
    rd(5'd9, v);  chk("count_rel1", v, 32'd1);
    rd(5'd14, v); chk("epc_rst", v, 32'd0);

    // exception entry
    pc = 32'h100; exception = 1'b1; ex_type = 5'd8;
    #1;
    chk("exc_redirect", {31'b0, redirect}, 32'd1);
    chk("exc_rpc", redirect_pc, 32'h4);
    cyc();
    exception = 1'b0;
    rd(5'd14, v); chk("exc_epc", v, 32'h0040_0100);
    rd(5'd13, v); chk("exc_code", {27'b0, v[6:2]}, 32'd8);
    rd(5'd12, v); chk("exc_status", v, 32'h2);

    // eret returns, second eret ignored
    eret = 1'b1;
    #1;
    chk("eret_redirect", {31'b0, redirect}, 32'd1);
    chk("eret_rpc", redirect_pc, 32'h0040_0100);
    cyc();
    rd(5'd12, v); chk("eret_status", v, 32'h0);
    chk("eret2_redirect", {31'b0, redirect}, 32'd0);
    eret = 1'b0;

    // nested exception keeps EPC; mtc0 lost under exception
    pc = 32'h200; exception = 1'b1; ex_type = 5'd4;
    cyc();
    pc = 32'h300; ex_type = 5'd9;
    mtc0 = 1'b1; addr = 5'd12; wdata = 32'h0000_FF01;
    cyc();
    mtc0 = 1'b0; exception = 1'b0;
    rd(5'd14, v); chk("nest_epc", v, 32'h0040_0200);
    rd(5'd13, v); chk("nest_code", {27'b0, v[6:2]}, 32'd9);
    rd(5'd12, v); chk("mtc0_lost", v, 32'h2);
    eret = 1'b1; cyc(); eret = 1'b0;

    // external irq: 2 sync flops plus IP register
    wr(5'd12, 32'h0000_0401);
    irq = 6'b000001; pc = 32'h500;
    #1;
    chk("irq_t0", {31'b0, irq_take}, 32'd0);
    cyc(); chk("irq_t1", {31'b0, irq_take}, 32'd0);
    cyc(); chk("irq_t2", {31'b0, irq_take}, 32'd0);
    cyc(); chk("irq_t3", {31'b0, irq_take}, 32'd1);
    chk("irq_rpc", redirect_pc, 32'h4);
    cyc();
    irq = 6'b0;
    chk("irq_exl", {31'b0, irq_take}, 32'd0);
    rd(5'd14, v); chk("irq_epc", v, 32'h0040_0500);
    rd(5'd13, v); chk("irq_code", {27'b0, v[6:2]}, 32'd0);
    repeat (4) cyc();
    eret = 1'b1; cyc(); eret = 1'b0;

    // masked line never taken
    wr(5'd12, 32'h0000_0001);
    irq = 6'b000001;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      seen = seen | irq_take;
    end
    chk("masked", {31'b0, seen}, 32'd0);
    rd(5'd13, v); chk("masked_ip2", {31'b0, v[10]}, 32'd1);

    // exception and irq together: exception wins
    wr(5'd12, 32'h0000_0401);
    pc = 32'h600; exception = 1'b1; ex_type = 5'd12;
    #1;
    chk("col_take", {31'b0, irq_take}, 32'd0);
    chk("col_redirect", {31'b0, redirect}, 32'd1);
    cyc();
    exception = 1'b0; irq = 6'b0;
    rd(5'd13, v); chk("col_code", {27'b0, v[6:2]}, 32'd12);
    rd(5'd14, v); chk("col_epc", v, 32'h0040_0600);
    repeat (4) cyc();
    eret = 1'b1; cyc(); eret = 1'b0;

    // timer: Count=0, Compare=10, TI after count hits 10
    wr(5'd11, 32'd10);
    rd(5'd13, v); chk("ti_clr", {31'b0, v[30]}, 32'd0);
    wr(5'd12, 32'h0000_8001);
    wr(5'd9, 32'd0);
    rd(5'd9, v); chk("count_load", v, 32'd0);
    pc = 32'h700;
    for (int k = 1; k <= 11; k++) begin
      cyc();
      if (k == 10) chk("tmr_k10", {31'b0, irq_take}, 32'd0);
      if (k == 11) chk("tmr_k11", {31'b0, irq_take}, 32'd1);
    end
    rd(5'd9, v);  chk("tmr_count", v, 32'd11);
    rd(5'd13, v); chk("tmr_ti", {31'b0, v[30]}, 32'd1);
    chk("tmr_ip7", {31'b0, v[15]}, 32'd1);
    cyc();
    rd(5'd14, v); chk("tmr_epc", v, 32'h0040_0700);
    wr(5'd11, 32'hFFFF_0000);
    rd(5'd13, v); chk("tmr_ticlr", {31'b0, v[30]}, 32'd0);
    eret = 1'b1; cyc(); eret = 1'b0;
    chk("tmr_none", {31'b0, irq_take}, 32'd0);

    // Count wrap
    wr(5'd9, 32'hFFFF_FFFF);
    rd(5'd9, v); chk("wrap_pre", v, 32'hFFFF_FFFF);
    cyc();
    rd(5'd9, v); chk("wrap_post", v, 32'd0);

    // masks, unmapped register, idle rdata
    wr(5'd12, 32'hFFFF_FFFC);
    rd(5'd12, v); chk("status_mask", v, 32'h0000_FF00);
    wr(5'd5, 32'h1234_5678);
    rd(5'd5, v); chk("unmapped", v, 32'd0);
    addr = 5'd12; mfc0 = 1'b0;
    #1;
    chk("rdata_idle", rdata, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
